sweep_capture_engine: RTL and testbench
=======================================

# sweep_capture_engine

Synthesizable exhaustive-sweep stimulus and response capture engine for trojan-detection data collection. On `start` it drives every value of an N_WIDTH-bit input space onto a device under test, in binary or Gray order. After a programmable settle time it samples the DUT response and streams {pattern, response} records out through a FIFO with a valid/ready handshake. An optional MISR compacts all responses into one signature for golden-model comparison.

## Interface
Parameters:
- N_WIDTH, 5, width of the swept input pattern (1..16)
- OUT_WIDTH, 1, width of the DUT response (1..SIG_WIDTH)
- SETTLE_CYCLES, 1, cycles a pattern is held before sampling (>=1)
- FIFO_DEPTH, 4, record FIFO entries (power of two, >=2)
- SIG_WIDTH, 16, MISR width (fixed polynomial x^16+x^12+x^5+1 when 16)

Ports:
- CK  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state and flushes FIFO
- start  in  1  begin sweep; sampled only in IDLE
- gray_mode  in  1  0 = binary order, 1 = Gray order; latched at start
- pat_out  out  N_WIDTH  pattern applied to DUT; reset 0
- dut_resp  in  OUT_WIDTH  DUT response
- rec_valid  out  1  FIFO head valid; reset 0
- rec_ready  in  1  consumer accepts head
- rec_pat  out  N_WIDTH  head pattern; 0 when empty
- rec_resp  out  OUT_WIDTH  head response; 0 when empty
- busy  out  1  high in any state but IDLE; reset 0
- done  out  1  one-cycle pulse at sweep completion; reset 0
- signature  out  SIG_WIDTH  MISR result; reset 0

## Operation
- Internal index idx (N_WIDTH bits). pat_out = idx (binary) or idx ^ (idx>>1) (Gray).
- States:
  - IDLE: on start, idx=0, latch gray_mode, clear MISR, go to APPLY.
  - APPLY: hold pat_out for SETTLE_CYCLES cycles, then go to SAMPLE.
  - SAMPLE: if FIFO not full, push {pat_out, dut_resp} and update MISR. Then, if idx is all-ones, go to DRAIN; else idx+1 and go to APPLY. If FIFO is full, stay in SAMPLE with pat_out held and retry each cycle.
  - DRAIN: wait for FIFO empty, then go to DONE.
  - DONE: assert done for one cycle, then go to IDLE.
- Sweep covers exactly 2^N_WIDTH records; idx never wraps within a sweep.
- FIFO is first-word-fall-through. A pop occurs when rec_valid && rec_ready. A simultaneous push and pop when full is allowed only if pop is evaluated first; a full FIFO with rec_ready high accepts the push in the same cycle.
- start while busy is ignored. reset in any state returns to IDLE, pat_out=0, FIFO empty, signature=0; no done pulse.
- signature holds its final value from DONE until the next start.

## Timing
- Start edge = edge 0. pat_out shows pattern k after edge k*(SETTLE_CYCLES+1).
- Response for pattern k is captured at edge k*(SETTLE_CYCLES+1)+SETTLE_CYCLES+1.
- With rec_ready held high, the sweep takes 2^N_WIDTH*(SETTLE_CYCLES+1) cycles plus 2 drain cycles.
- rec_valid rises in the cycle after the first push. Record latency from push to head of an empty FIFO is 1 cycle.
- Each cycle of backpressure in SAMPLE adds exactly one cycle; no record is lost or duplicated.

## Configuration
- SWEEP_SIGNATURE_EN defined:
  - MISR is instantiated.
  - On each push: sig <= {sig[SIG_WIDTH-2:0],0} ^ (sig[SIG_WIDTH-1] ? POLY : 0) ^ zero-extended dut_resp.
  - The result is driven on signature.
- Not defined:
  - No MISR logic.
  - signature is tied to 0.
  - All other behaviour is identical.

## Test plan
- Binary sweep:
  - Setup: N_WIDTH=5, SETTLE_CYCLES=1, loopback dut_resp = pat_out[0]^pat_out[4], rec_ready=1.
  - Required: 32 records with pat 0..31 in order and matching resp.
  - Required: done pulses after edge 66; busy low after edge 67.
- Gray sweep:
  - Setup: gray_mode=1.
  - Required: records 0,1,3,2,6,…,16 (idx^(idx>>1)).
  - Required: adjacent records differ in exactly one bit.
- Backpressure:
  - Setup: FIFO_DEPTH=4, rec_ready=0 for 20 cycles, then 1.
  - Required: FSM stalls in SAMPLE with pat_out=4 and FIFO holding 0..3.
  - Required: after release, all 32 records arrive once each, in order.
- Reset mid-sweep:
  - Stimulus: assert reset during pattern 10.
  - Required: next cycle pat_out=0, rec_valid=0, busy=0, no done.
  - Required: a new start sweeps again from 0.
- start during busy:
  - Stimulus: pulse start at pattern 7.
  - Required: no effect; sweep completes normally with 32 records.
- Signature (SWEEP_SIGNATURE_EN):
  - Setup: dut_resp tied to 0.
  - Required: signature=0.
  - Setup: dut_resp = pat_out[0].
  - Required: signature equals the software MISR model over the 32 responses, and is stable after done.

Source files
------------

// File: rtl/sweep_capture_engine.sv
// Exhaustive-sweep stimulus generator with settle/sample sequencing and a FWFT record FIFO.
// Optional response MISR is enabled by defining SWEEP_SIGNATURE_EN.
module sweep_capture_engine #(
  parameter int unsigned N_WIDTH       = 5,
  parameter int unsigned OUT_WIDTH     = 1,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SIG_WIDTH     = 16
) (
  input  logic                 CK,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 gray_mode,
  output logic [N_WIDTH-1:0]   pat_out,
  input  logic [OUT_WIDTH-1:0] dut_resp,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [N_WIDTH-1:0]   rec_pat,
  output logic [OUT_WIDTH-1:0] rec_resp,
  output logic                 busy,
  output logic                 done,
  output logic [SIG_WIDTH-1:0] signature
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned RecW = N_WIDTH + OUT_WIDTH;

  typedef enum logic [2:0] {StIdle, StApply, StSample, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [N_WIDTH-1:0]  idx_q;
  logic [CntW-1:0]     cnt_q;
  logic                gray_q;
  logic [RecW-1:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]       count_q;
  logic                fifo_empty, fifo_full, push, pop, idx_last, settle_done, launch;

  assign pat_out     = gray_q ? (idx_q ^ (idx_q >> 1)) : idx_q;
  assign idx_last    = &idx_q;
  assign settle_done = (cnt_q == CntW'(SETTLE_CYCLES - 1));
  assign launch      = (state_q == StIdle) && start;
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == (PtrW + 1)'(FIFO_DEPTH));
  assign pop         = rec_valid && rec_ready;
  // Pop is evaluated first, so a full FIFO being drained still accepts the push.
  assign push        = (state_q == StSample) && (!fifo_full || pop);

  always_ff @(posedge CK) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start) state_d = StApply;
      StApply:  if (settle_done) state_d = StSample;
      StSample: if (push) state_d = idx_last ? StDrain : StApply;
      StDrain:  if (fifo_empty) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  always_ff @(posedge CK) begin
    if (reset) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      gray_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            gray_q <= gray_mode;
          end
        end
        StApply:  cnt_q <= settle_done ? '0 : cnt_q + CntW'(1);
        StSample: if (push && !idx_last) idx_q <= idx_q + N_WIDTH'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge CK) begin
    if (push) mem_q[wr_ptr_q] <= {pat_out, dut_resp};
  end

  always_ff @(posedge CK) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    rec_valid = !fifo_empty;
    rec_pat   = '0;
    rec_resp  = '0;
    if (!fifo_empty) {rec_pat, rec_resp} = mem_q[rd_ptr_q];
  end

`ifdef SWEEP_SIGNATURE_EN
  // x^16 + x^12 + x^5 + 1
  localparam logic [SIG_WIDTH-1:0] Poly = SIG_WIDTH'(32'h0000_1021);
  logic [SIG_WIDTH-1:0] sig_q;

  always_ff @(posedge CK) begin
    if (reset || launch) begin
      sig_q <= '0;
    end else if (push) begin
      sig_q <= {sig_q[SIG_WIDTH-2:0], 1'b0} ^ (sig_q[SIG_WIDTH-1] ? Poly : '0)
               ^ SIG_WIDTH'(dut_resp);
    end
  end

  assign signature = sig_q;
`else
  assign signature = '0;
`endif

endmodule

// File: tb/tb_sweep_capture_engine.sv
// Scoreboard bench for sweep_capture_engine: expected records queued at start, monitor pops on handshake.
module tb_sweep_capture_engine;

  logic       CK;
  logic       reset, start, gray_mode, rec_ready;
  logic [4:0] pat_out, rec_pat;
  logic       dut_resp, rec_valid, rec_resp, busy, done;
  logic [15:0] signature;

  logic       resp_tbl [32];
  logic [5:0] exp_q [$];
  int n_cmp = 0, n_mis = 0;
  int rx_count = 0, done_cnt = 0, rx_base = 0, dc_base = 0;
  bit chk_gray = 0, have_prev = 0, cur_gray = 0;
  logic [4:0] prev_pat;

  assign dut_resp = resp_tbl[pat_out];

  sweep_capture_engine #(
    .N_WIDTH(5), .OUT_WIDTH(1), .SETTLE_CYCLES(1), .FIFO_DEPTH(4), .SIG_WIDTH(16)
  ) dut (
    .CK(CK), .reset(reset), .start(start), .gray_mode(gray_mode), .pat_out(pat_out),
    .dut_resp(dut_resp), .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_pat(rec_pat),
    .rec_resp(rec_resp), .busy(busy), .done(done), .signature(signature)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_mis++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic monitor();
    logic [5:0] e;
    forever begin
      @(negedge CK);
      if (done) done_cnt++;
      if (rec_valid && rec_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_record: got pat=%0d resp=%0d, required none", rec_pat, rec_resp);
        end else begin
          e = exp_q.pop_front();
          check("record_pat", int'(rec_pat), int'(e[5:1]));
          check("record_resp", int'(rec_resp), int'(e[0]));
        end
        if (chk_gray && have_prev) check("gray_one_bit", $countones(rec_pat ^ prev_pat), 1);
        prev_pat  = rec_pat;
        have_prev = 1;
        rx_count++;
      end
    end
  endtask

  // 0: p[0]^p[4], 1: zero, 2: p[0], 3: random
  task automatic fill_tbl(input int mode);
    for (int p = 0; p < 32; p++) begin
      case (mode)
        0:       resp_tbl[p] = p[0] ^ p[4];
        1:       resp_tbl[p] = 1'b0;
        2:       resp_tbl[p] = p[0];
        default: resp_tbl[p] = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  function automatic int sweep_pat(input int k, input bit g);
    return g ? (k ^ (k >> 1)) : k;
  endfunction

  function automatic logic [15:0] misr_model(input bit g);
    logic [15:0] sig;
    sig = '0;
    for (int k = 0; k < 32; k++)
      sig = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000)
            ^ {15'b0, resp_tbl[sweep_pat(k, g)]};
    return sig;
  endfunction

  // Called #1 after a rising edge; returns #1 after the start edge.
  task automatic start_sweep(input bit g);
    exp_q.delete();
    for (int k = 0; k < 32; k++) begin
      int p;
      p = sweep_pat(k, g);
      exp_q.push_back({5'(p), resp_tbl[p]});
    end
    cur_gray  = g;
    chk_gray  = g;
    have_prev = 0;
    rx_base   = rx_count;
    dc_base   = done_cnt;
    gray_mode = g;
    start     = 1'b1;
    @(posedge CK); #1;
    start     = 1'b0;
    gray_mode = 1'b0;
    check("busy_after_start", busy, 1);
    check("pat0_after_start", int'(pat_out), sweep_pat(0, g));
  endtask

  task automatic wait_done(input bit rand_ready, input string tag);
    bit seen;
    seen = 0;
    for (int n = 0; n < 3000 && !seen; n++) begin
      @(posedge CK); #1;
      if (done) seen = 1;
      else if (rand_ready) rec_ready = 1'($urandom_range(0, 1));
    end
    rec_ready = 1'b1;
    check({tag, "_done_seen"}, seen, 1);
  endtask

  task automatic end_checks(input string tag);
    logic [15:0] sig_exp;
`ifdef SWEEP_SIGNATURE_EN
    sig_exp = misr_model(cur_gray);
`else
    sig_exp = '0;
`endif
    @(posedge CK); #1;
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_record_count"}, rx_count - rx_base, 32);
    check({tag, "_done_pulses"}, done_cnt - dc_base, 1);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_signature"}, int'(signature), int'(sig_exp));
    repeat (3) @(posedge CK);
    #1 check({tag, "_signature_stable"}, int'(signature), int'(sig_exp));
  endtask

  initial begin
    int done_edge, busy_edge;
    bit found;
    reset = 1'b1; start = 1'b0; gray_mode = 1'b0; rec_ready = 1'b1;
    fill_tbl(0);
    fork
      monitor();
    join_none
    repeat (3) @(posedge CK);
    #1;
    check("rst_pat_out", int'(pat_out), 0);
    check("rst_rec_valid", rec_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_signature", int'(signature), 0);
    reset = 1'b0;
    @(posedge CK); #1;

    // Binary sweep with edge-accurate timing
    start_sweep(0);
    done_edge = -1;
    busy_edge = -1;
    for (int e = 1; e <= 70; e++) begin
      @(posedge CK); #1;
      if (e <= 63 && (e % 4 == 0 || e == 63)) check("bin_pat_timing", int'(pat_out), e / 2);
      if (done && done_edge < 0) done_edge = e;
      if (!busy && busy_edge < 0) busy_edge = e;
    end
    check("bin_done_edge", done_edge, 66);
    check("bin_busy_low_edge", busy_edge, 67);
    check("bin_queue_empty", exp_q.size(), 0);
    check("bin_record_count", rx_count - rx_base, 32);
    check("bin_done_pulses", done_cnt - dc_base, 1);

    // Gray sweep
    start_sweep(1);
    wait_done(0, "gray");
    end_checks("gray");

    // Backpressure: consumer stalls for 20 cycles
    rec_ready = 1'b0;
    start_sweep(0);
    for (int e = 1; e <= 20; e++) begin
      @(posedge CK); #1;
      if (e == 12 || e == 20) begin
        check("bp_pat_held", int'(pat_out), 4);
        check("bp_busy", busy, 1);
        check("bp_head_valid", rec_valid, 1);
        check("bp_head_pat", int'(rec_pat), 0);
      end
    end
    rec_ready = 1'b1;
    wait_done(0, "bp");
    end_checks("bp");

    // Reset mid-sweep during pattern 10
    start_sweep(0);
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(posedge CK); #1;
      if (pat_out == 5'd10) found = 1;
    end
    check("rst_mid_reached_pat10", found, 1);
    dc_base   = done_cnt;
    reset     = 1'b1;
    rec_ready = 1'b0;
    @(posedge CK); #1;
    reset = 1'b0;
    exp_q.delete();
    check("rst_mid_pat_out", int'(pat_out), 0);
    check("rst_mid_rec_valid", rec_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_signature", int'(signature), 0);
    rec_ready = 1'b1;
    repeat (5) @(posedge CK);
    #1 check("rst_mid_no_done", done_cnt - dc_base, 0);
    start_sweep(0);
    wait_done(0, "rst_restart");
    end_checks("rst_restart");

    // start pulse (with gray requested) mid-sweep is ignored
    start_sweep(0);
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(posedge CK); #1;
      if (pat_out == 5'd7) found = 1;
    end
    check("busy_start_reached_pat7", found, 1);
    gray_mode = 1'b1;
    start     = 1'b1;
    @(posedge CK); #1;
    start     = 1'b0;
    gray_mode = 1'b0;
    wait_done(0, "busy_start");
    end_checks("busy_start");

    // Signature with constant-zero and pat_out[0] responses
    fill_tbl(1);
    start_sweep(0);
    wait_done(0, "sig_zero");
    end_checks("sig_zero");
    check("sig_zero_value", int'(signature), 0);
    fill_tbl(2);
    start_sweep(0);
    wait_done(0, "sig_pat0");
    end_checks("sig_pat0");

    // Randomized response tables, order and consumer backpressure
    for (int r = 0; r < 4; r++) begin
      fill_tbl(3);
      start_sweep(1'($urandom_range(0, 1)));
      wait_done(1, "rand");
      end_checks("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
